// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_queue
// Description : Write-back front end for the 16x16 register file. Merges the
//               load and ALU result streams into the single write port via a
//               small in-order queue, forwards pending write data to decode,
//               and sequences halt so the register dump follows the last write.
// Options     : RF_WB_FWD_EN - when defined, pending data is forwarded to the
//               decode read ports; when undefined, decode is interlocked via
//               stall until the matching write has retired.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_vld,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       alu_vld,
    input  logic [ADDR_W-1:0]          alu_addr,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       stall,
    input  logic [ADDR_W-1:0]          rd0_addr,
    input  logic [ADDR_W-1:0]          rd1_addr,
    output logic                       fwd0_hit,
    output logic [DATA_W-1:0]          fwd0_data,
    output logic                       fwd1_hit,
    output logic [DATA_W-1:0]          fwd1_data,
    input  logic                       hlt_in,
    output logic [ADDR_W-1:0]          dst_addr,
    output logic [DATA_W-1:0]          dst,
    output logic                       we,
    output logic                       hlt,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_W-1:0]      r_q_addr [DEPTH];
    logic [DATA_W-1:0]      r_q_data [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [ADDR_W-1:0]      r_dst_addr;
    logic [DATA_W-1:0]      r_dst;
    logic                   r_we;
    logic                   r_ovf;

    logic                   w_accept;
    logic                   w_ld_req;
    logic                   w_alu_req;
    logic                   w_ld_push;
    logic                   w_alu_push;
    logic                   w_drop;
    logic                   w_pop;
    logic [c_CNT_W-1:0]     w_cnt_after_ld;
    logic [c_PTR_W-1:0]     w_alu_slot;
    logic                   w_hit0;
    logic                   w_hit1;
    logic                   w_interlock;

    // Per-slot view of the queue ordered oldest (0) to newest (DEPTH-1)
    logic                   w_slot_vld  [DEPTH];
    logic [ADDR_W-1:0]      w_slot_addr [DEPTH];

    // Results are refused entirely once halted; R0 writes are never queued.
    // Capacity is judged on the occupancy before this cycle's pop, ld first.
    assign w_accept       = (r_state != S_HALTED);
    assign w_ld_req       = ld_vld  && (ld_addr  != '0) && w_accept;
    assign w_alu_req      = alu_vld && (alu_addr != '0) && w_accept;
    assign w_ld_push      = w_ld_req && (r_count < c_CNT_W'(DEPTH));
    assign w_cnt_after_ld = r_count + c_CNT_W'(w_ld_push);
    assign w_alu_push     = w_alu_req && (w_cnt_after_ld < c_CNT_W'(DEPTH));
    assign w_drop         = (w_ld_req && !w_ld_push) || (w_alu_req && !w_alu_push);
    assign w_pop          = (r_count != '0);
    assign w_alu_slot     = r_wr_ptr + c_PTR_W'(w_ld_push);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [c_PTR_W-1:0] w_idx;
            assign w_idx          = r_rd_ptr + c_PTR_W'(i);
            assign w_slot_vld[i]  = (c_CNT_W'(i) < r_count);
            assign w_slot_addr[i] = r_q_addr[w_idx];
        end
    endgenerate

    // Queue storage; only slots inside the valid window are ever observed
    always_ff @(posedge clk) begin
        if (w_ld_push) begin
            r_q_addr[r_wr_ptr] <= ld_addr;
            r_q_data[r_wr_ptr] <= ld_data;
        end
        if (w_alu_push) begin
            r_q_addr[w_alu_slot] <= alu_addr;
            r_q_data[w_alu_slot] <= alu_data;
        end
    end

    // Pointers, occupancy, registered write port and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dst_addr <= '0;
            r_dst      <= '0;
            r_we       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_ld_push) + c_PTR_W'(w_alu_push);
            r_count  <= r_count + c_CNT_W'(w_ld_push) + c_CNT_W'(w_alu_push)
                        - c_CNT_W'(w_pop);
            r_we     <= w_pop;
            if (w_pop) begin
                r_dst_addr <= r_q_addr[r_rd_ptr];
                r_dst      <= r_q_data[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Halt state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt next-state: drain completes only when nothing is queued, in the
    // output register, or arriving this cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (hlt_in) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_count == '0) && !r_we && !w_ld_push && !w_alu_push) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Pending-write match for each read port (output register or any slot)
    always_comb begin
        w_hit0 = r_we && (r_dst_addr == rd0_addr);
        w_hit1 = r_we && (r_dst_addr == rd1_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_vld[i] && (w_slot_addr[i] == rd0_addr)) begin
                w_hit0 = 1'b1;
            end
            if (w_slot_vld[i] && (w_slot_addr[i] == rd1_addr)) begin
                w_hit1 = 1'b1;
            end
        end
        if (rd0_addr == '0) begin
            w_hit0 = 1'b0;
        end
        if (rd1_addr == '0) begin
            w_hit1 = 1'b0;
        end
    end

`ifdef RF_WB_FWD_EN
    logic [DATA_W-1:0]      w_slot_data [DEPTH];
    logic [DATA_W-1:0]      w_data0;
    logic [DATA_W-1:0]      w_data1;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot_data
            assign w_slot_data[i] = r_q_data[g_slot[i].w_idx];
        end
    endgenerate

    // Forwarded data: youngest match wins, so scan oldest-to-newest after
    // the output register and let later matches override earlier ones
    always_comb begin
        w_data0 = '0;
        w_data1 = '0;
        if (r_we && (r_dst_addr == rd0_addr)) begin
            w_data0 = r_dst;
        end
        if (r_we && (r_dst_addr == rd1_addr)) begin
            w_data1 = r_dst;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_vld[i] && (w_slot_addr[i] == rd0_addr)) begin
                w_data0 = w_slot_data[i];
            end
            if (w_slot_vld[i] && (w_slot_addr[i] == rd1_addr)) begin
                w_data1 = w_slot_data[i];
            end
        end
        if (!w_hit0) begin
            w_data0 = '0;
        end
        if (!w_hit1) begin
            w_data1 = '0;
        end
    end

    assign fwd0_hit    = w_hit0;
    assign fwd1_hit    = w_hit1;
    assign fwd0_data   = w_data0;
    assign fwd1_data   = w_data1;
    assign w_interlock = 1'b0;
`else
    assign fwd0_hit    = 1'b0;
    assign fwd1_hit    = 1'b0;
    assign fwd0_data   = '0;
    assign fwd1_data   = '0;
    assign w_interlock = w_hit0 || w_hit1;
`endif

    assign stall    = (r_count > c_CNT_W'(DEPTH - 2)) || (r_state == S_HALTED) || w_interlock;
    assign hlt      = (r_state == S_HALTED);
    assign dst_addr = r_dst_addr;
    assign dst      = r_dst;
    assign we       = r_we;
    assign count    = r_count;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_queue
// Description : Self-checking bench for rf_wb_queue. A reference model queues
//               expected register writes as stimulus is applied; a monitor
//               pops and compares them as the write port fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              ld_vld;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              alu_vld;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              stall;
    logic [ADDR_W-1:0] rd0_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic              fwd0_hit;
    logic [DATA_W-1:0] fwd0_data;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              hlt_in;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst;
    logic              we;
    logic              hlt;
    logic [2:0]        count;
    logic              ovf;

    rf_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_vld    (ld_vld),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_vld   (alu_vld),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .stall     (stall),
        .rd0_addr  (rd0_addr),
        .rd1_addr  (rd1_addr),
        .fwd0_hit  (fwd0_hit),
        .fwd0_data (fwd0_data),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .hlt_in    (hlt_in),
        .dst_addr  (dst_addr),
        .dst       (dst),
        .we        (we),
        .hlt       (hlt),
        .count     (count),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t sbq[$];
    int  checks   = 0;
    int  errors   = 0;
    int  m_cnt    = 0;
    bit  m_ovf    = 1'b0;
    bit  m_ignore = 1'b0;
    int  m_pushes;
    bit  m_pop;
    int  n_writes = 0;
    wr_t exp_wr;

    // Reference model: occupancy, acceptance and expected write order
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_ovf = 1'b0;
            sbq.delete();
        end else begin
            m_pushes = 0;
            m_pop    = (m_cnt != 0);
            if (!m_ignore) begin
                if (ld_vld && ld_addr != 0) begin
                    if (m_cnt + m_pushes < DEPTH) begin
                        sbq.push_back('{a: ld_addr, d: ld_data});
                        m_pushes++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (alu_vld && alu_addr != 0) begin
                    if (m_cnt + m_pushes < DEPTH) begin
                        sbq.push_back('{a: alu_addr, d: alu_data});
                        m_pushes++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            m_cnt = m_cnt + m_pushes - (m_pop ? 1 : 0);
        end
    end

    // Monitor: occupancy, overflow flag and retired writes against the model
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (count !== 3'(m_cnt)) begin
                errors++;
                $display("FAIL count: got %0d expected %0d at %0t", count, m_cnt, $time);
            end
            checks++;
            if (ovf !== m_ovf) begin
                errors++;
                $display("FAIL ovf: got %b expected %b at %0t", ovf, m_ovf, $time);
            end
            if (we === 1'b1) begin
                n_writes++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected write R%0d=%h at %0t", dst_addr, dst, $time);
                end else begin
                    exp_wr = sbq.pop_front();
                    if (dst_addr !== exp_wr.a || dst !== exp_wr.d) begin
                        errors++;
                        $display("FAIL write: got R%0d=%h expected R%0d=%h at %0t",
                                 dst_addr, dst, exp_wr.a, exp_wr.d, $time);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ld_vld   = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        alu_vld  = 1'b0;
        alu_addr = '0;
        alu_data = '0;
        hlt_in   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m_ignore = 1'b0;
        clear_inputs();
        rd0_addr = '0;
        rd1_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || m_cnt != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes still outstanding after timeout", sbq.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 3'd0 || we !== 1'b0 || hlt !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: count=%0d we=%b hlt=%b ovf=%b expected 0 0 0 0",
                     count, we, hlt, ovf);
        end
        checks++;
        if (dst_addr !== 4'd0 || dst !== 16'h0) begin
            errors++;
            $display("FAIL reset_dst: dst_addr=%0d dst=%h expected 0 0000", dst_addr, dst);
        end
        checks++;
        if (stall !== 1'b0 || fwd0_hit !== 1'b0 || fwd1_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: stall=%b fwd0=%b fwd1=%b expected 0 0 0",
                     stall, fwd0_hit, fwd1_hit);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        ld_vld = 1'b1; ld_addr = 4'd3; ld_data = 16'hBEEF;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (we !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_enq: we=%b count=%0d expected 0 1", we, count);
        end
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || dst_addr !== 4'd3 || dst !== 16'hBEEF || count !== 3'd0) begin
            errors++;
            $display("FAIL single_wr: we=%b R%0d=%h count=%0d expected 1 R3=beef 0",
                     we, dst_addr, dst, count);
        end
        @(negedge clk);
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: we=%b expected 0", we);
        end
        wait_drain();
    endtask

    task automatic test_dual_push();
        bit exp_hit [4];
        exp_hit = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        rd0_addr = 4'd5;
        ld_vld  = 1'b1; ld_addr  = 4'd5; ld_data  = 16'h1111;
        alu_vld = 1'b1; alu_addr = 4'd5; alu_data = 16'h2222;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_inputs();
            checks++;
`ifdef RF_WB_FWD_EN
            if (fwd0_hit !== exp_hit[c] || (exp_hit[c] && fwd0_data !== 16'h2222)
                || stall !== 1'b0) begin
                errors++;
                $display("FAIL dual_fwd c%0d: hit=%b data=%h stall=%b expected %b 2222 0",
                         c, fwd0_hit, fwd0_data, stall, exp_hit[c]);
            end
`else
            if (fwd0_hit !== 1'b0 || fwd0_data !== 16'h0 || stall !== exp_hit[c]) begin
                errors++;
                $display("FAIL dual_lock c%0d: hit=%b data=%h stall=%b expected 0 0000 %b",
                         c, fwd0_hit, fwd0_data, stall, exp_hit[c]);
            end
`endif
        end
        rd0_addr = '0;
        wait_drain();
    endtask

    task automatic test_r0_discard();
        do_reset();
        rd1_addr = 4'd0;
        alu_vld = 1'b1; alu_addr = 4'd0; alu_data = 16'hFFFF;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (count !== 3'd0 || fwd1_hit !== 1'b0) begin
            errors++;
            $display("FAIL r0_enq: count=%0d fwd1=%b expected 0 0", count, fwd1_hit);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (we !== 1'b0) begin
                errors++;
                $display("FAIL r0_we c%0d: we=%b expected 0", c, we);
            end
        end
    endtask

    task automatic test_full();
        bit exp_stall [3];
        int w0;
        exp_stall = '{1'b0, 1'b1, 1'b1};
        do_reset();
        w0 = n_writes;
        for (int c = 0; c < 3; c++) begin
            ld_vld  = 1'b1; ld_addr  = 4'(1 + 2 * c); ld_data  = 16'hA000 + 16'(2 * c);
            alu_vld = 1'b1; alu_addr = 4'(2 + 2 * c); alu_data = 16'hA001 + 16'(2 * c);
            @(negedge clk);
            checks++;
            if (stall !== exp_stall[c]) begin
                errors++;
                $display("FAIL full_stall c%0d: stall=%b expected %b", c, stall, exp_stall[c]);
            end
        end
        clear_inputs();
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL full_ovf: ovf=%b expected 1", ovf);
        end
        wait_drain();
        checks++;
        if (n_writes - w0 != 5) begin
            errors++;
            $display("FAIL full_retired: %0d writes expected 5", n_writes - w0);
        end
    endtask

    task automatic test_halt();
        bit prev_we;
        bit fell;
        int w0;
        do_reset();
        w0 = n_writes;
        ld_vld = 1'b1; ld_addr = 4'd2; ld_data = 16'h0C01;
        @(negedge clk);
        ld_addr = 4'd4; ld_data = 16'h0C02;
        @(negedge clk);
        ld_addr = 4'd6; ld_data = 16'h0C03; hlt_in = 1'b1;
        @(negedge clk);
        clear_inputs();
        prev_we = we;
        fell    = 1'b0;
        for (int c = 0; c < 20 && !fell; c++) begin
            @(negedge clk);
            checks++;
            if (hlt !== 1'b0) begin
                errors++;
                $display("FAIL halt_early c%0d: hlt=%b expected 0", c, hlt);
            end
            if (prev_we && !we) begin
                fell = 1'b1;
            end
            prev_we = we;
        end
        checks++;
        if (!fell || n_writes - w0 != 3) begin
            errors++;
            $display("FAIL halt_drain: fell=%b writes=%0d expected 1 3", fell, n_writes - w0);
        end
        @(negedge clk);
        checks++;
        if (hlt !== 1'b1) begin
            errors++;
            $display("FAIL halt_rise: hlt=%b expected 1", hlt);
        end
        m_ignore = 1'b1;
        ld_vld = 1'b1; ld_addr = 4'd9; ld_data = 16'hDEAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (hlt !== 1'b1 || stall !== 1'b1 || ovf !== 1'b0 || count !== 3'd0 || we !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold c%0d: hlt=%b stall=%b ovf=%b count=%0d we=%b expected 1 1 0 0 0",
                         c, hlt, stall, ovf, count, we);
            end
        end
        clear_inputs();
    endtask

    task automatic test_interlock();
        bit exp_pend [3];
        exp_pend = '{1'b1, 1'b1, 1'b0};
        do_reset();
        rd0_addr = 4'd7;
        ld_vld = 1'b1; ld_addr = 4'd7; ld_data = 16'h7777;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs();
            checks++;
`ifdef RF_WB_FWD_EN
            if (fwd0_hit !== exp_pend[c] || (exp_pend[c] && fwd0_data !== 16'h7777)
                || stall !== 1'b0) begin
                errors++;
                $display("FAIL r7_fwd c%0d: hit=%b data=%h stall=%b expected %b 7777 0",
                         c, fwd0_hit, fwd0_data, stall, exp_pend[c]);
            end
`else
            if (stall !== exp_pend[c] || fwd0_hit !== 1'b0) begin
                errors++;
                $display("FAIL r7_lock c%0d: stall=%b hit=%b expected %b 0",
                         c, stall, fwd0_hit, exp_pend[c]);
            end
`endif
        end
        rd0_addr = '0;
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        rd0_addr = '0;
        rd1_addr = '0;
        test_reset();
        test_single_write();
        test_dual_push();
        test_r0_discard();
        test_full();
        test_halt();
        test_interlock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Write-back front end for the 16-entry, 16-bit triple-ported register file.
- Merges two result producers (load path and ALU path) into the register file's single write port through a small in-order queue.
- Forwards still-pending write data to the decode read ports.
- Sequences program halt so that the register file's halt dump happens only after all pending writes have retired.

Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- DATA_W, 16: register data width.
- ADDR_W, 4: register address width (16 registers).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ld_vld  in  1  load result valid.
- ld_addr  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load result.
- alu_vld  in  1  ALU result valid.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- stall  out  1  upstream must not present new results this cycle.
- rd0_addr  in  ADDR_W  decode read address, port 0.
- rd1_addr  in  ADDR_W  decode read address, port 1.
- fwd0_hit  out  1  pending write to rd0_addr exists.
- fwd0_data  out  DATA_W  newest pending data for rd0_addr.
- fwd1_hit  out  1  pending write to rd1_addr exists.
- fwd1_data  out  DATA_W  newest pending data for rd1_addr.
- hlt_in  in  1  halt request from the pipeline.
- dst_addr  out  ADDR_W  register file write address.
- dst  out  DATA_W  register file write data.
- we  out  1  register file write enable.
- hlt  out  1  halt to the register file (triggers its dump).
- count  out  $clog2(DEPTH)+1  current queue occupancy.
- ovf  out  1  sticky overflow error.

Behaviour:
- Reset (rst_n=0 at a rising edge): queue empty, count=0, we=0, dst_addr=0, dst=0, hlt=0, ovf=0, state RUN. Reset mid-drain discards all pending entries.
- Enqueue: results with addr==0 are discarded (R0 is hardwired zero). When both producers are valid in one cycle, the ld entry is enqueued first (older), then alu. Up to 2 enqueues per cycle.
- Dequeue: at most one per cycle. The head is popped into registered outputs dst_addr/dst with we=1 for exactly one cycle. If the queue is empty, we=0 and dst_addr/dst hold their values.
- Latency: an entry enqueued at edge N into an empty queue drives we=1 during the cycle after edge N+1.
- Simultaneous enqueue and dequeue are allowed; count = count + pushes − pop.
- stall = (DEPTH − count < 2) OR state HALTED. Combinational from registered state.
- Overflow: a push that finds the queue full is dropped and sets ovf=1. ovf clears only on reset.
- Forwarding (combinational):
  - Search the output register (when we=1) and all valid queue entries for addr match.
  - The youngest match wins: newest queue entry first, output register last.
  - rdX_addr==0 never hits.
  - Same-cycle incoming producer data is not forwarded.
- Halt FSM:
  - RUN: hlt_in=1 → DRAIN. Any results valid in that same cycle are still enqueued.
  - DRAIN: enqueues still accepted. When count==0 and we==0 → HALTED.
  - HALTED: hlt=1 held until reset; new results ignored (no ovf); stall=1.
  - hlt_in deasserting during DRAIN has no effect.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined: forwarding as described above.
- Undefined:
  - fwd0_hit=fwd1_hit=0 and fwd0_data=fwd1_data=0.
  - stall is additionally asserted while rd0_addr or rd1_addr (nonzero) matches any pending entry or the active output register. This is an interlock: decode waits for the write to retire.

Test Plan:
- Single write: reset; ld_vld=1, ld_addr=3, ld_data=16'hBEEF for 1 cycle → one cycle later we=1, dst_addr=3, dst=BEEF for exactly 1 cycle; count returns to 0.
- Dual push ordering: ld(5, 16'h1111) and alu(5, 16'h2222) in the same cycle → writes retire in order: 1111 then 2222; rd0_addr=5 before retire gives fwd0_hit=1, fwd0_data=2222.
- R0 discard: alu(0, 16'hFFFF) → no enqueue, count stays 0, we never asserted; rd1_addr=0 → fwd1_hit=0.
- Full/stall/ovf with DEPTH=4: push 2 per cycle for 3 cycles ignoring stall → stall=1 once count≥3; excess pushes dropped; ovf=1; retired writes match only accepted entries, in order.
- Halt drain: 3 entries pending, pulse hlt_in → hlt stays 0 until the 3rd write retires, rises the cycle after we falls, then holds; later ld_vld pushes are ignored with ovf=0.
- Macro off: build without RF_WB_FWD_EN; pending write to R7, rd0_addr=7 → stall=1 and fwd0_hit=0 until the R7 write retires, then stall=0.
